dmem_stall_responder: RTL and testbench

//  Responder end of the CPU data-side sram-like port: accepts sig_enM/sig_writeM/aluoutM/writedataM

---
 rtl/dmem_stall_responder_pkg.sv | 12 +
 rtl/dmem_stall_responder_bram_be.sv | 23 ++
 rtl/dmem_stall_responder.sv | 100 ++++++++++
 tb/tb_dmem_stall_responder.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_stall_responder_pkg.sv
// Shared types and constants for the data-memory stall responder.
package dmem_stall_responder_pkg;

  localparam int LAT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_stall_responder_bram_be.sv
// Word RAM with per-byte write enables and a registered read port; contents are never reset.
module bram_be #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic [3:0]        we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       q
);

  logic [31:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    // q holds its value between reads so it can serve directly as the read-data register
    if (re) q <= mem[addr];
  end

endmodule

// File: rtl/dmem_stall_responder.sv
// MEM-stage data memory responder: serves latched requests after LATENCY cycles and raises stall meanwhile.
module dmem_stall_responder
  import dmem_stall_responder_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [3:0]  wen,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        longest_stall,
  output logic [31:0] rdata,
  output logic        stall
);

  state_t             state, state_nxt;
  logic [LAT_W-1:0]   cnt;
  logic [ADDR_W-1:0]  idx_lat;
  logic [3:0]         wen_lat;
  logic [31:0]        wdata_lat;
  logic               capture, access, do_write, do_read;
  logic               rd_valid;
  logic [31:0]        ram_q;
  logic               unused_addr;

  assign unused_addr = ^{addr[31:ADDR_W+2], addr[1:0]};

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    access    = 1'b0;
    case (state)
      S_IDLE: begin
        if (en) begin
          capture   = 1'b1;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!en) begin
          state_nxt = S_IDLE;
        end else if (cnt == '0) begin
          access    = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        // A frozen pipeline keeps the same request on the port; it must not be served twice.
        if (!longest_stall) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign stall    = ((state == S_IDLE) && en) || (state == S_WAIT);
  assign do_write = access && !rst && (wen_lat != 4'b0000);
  assign do_read  = access && !rst && (wen_lat == 4'b0000);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      rd_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      if (capture) begin
        cnt <= LAT_W'(LATENCY - 1);
      end else if ((state == S_WAIT) && en && (cnt != '0)) begin
        cnt <= cnt - LAT_W'(1);
      end
      if (do_read) rd_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      idx_lat   <= addr[ADDR_W+1:2];
      wen_lat   <= wen;
      wdata_lat <= wdata;
    end
  end

  bram_be #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (do_write ? wen_lat : 4'b0000),
    .re    (do_read),
    .addr  (idx_lat),
    .wdata (wdata_lat),
    .q     (ram_q)
  );

  // Until the first read completes after reset the RAM output is meaningless, so present zero.
  assign rdata = rd_valid ? ram_q : 32'h0;

endmodule

// File: tb/tb_dmem_stall_responder.sv
// Self-checking bench for dmem_stall_responder against a word-array reference model.
module tb_dmem_stall_responder;

  localparam int ADDR_W = 10;
  localparam int LAT    = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [3:0]  wen = 4'h0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        longest_stall = 1'b0;
  logic [31:0] rdata;
  logic        stall;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] mem_m [int];
  logic [31:0] rd_m = 32'h0;

  dmem_stall_responder #(
    .ADDR_W  (ADDR_W),
    .LATENCY (LAT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .wen           (wen),
    .addr          (addr),
    .wdata         (wdata),
    .longest_stall (longest_stall),
    .rdata         (rdata),
    .stall         (stall)
  );

  always #5 clk = ~clk;

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % (1 << ADDR_W));
  endfunction

  task automatic model_apply(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] cur;
    cur = mem_m.exists(widx(a)) ? mem_m[widx(a)] : 32'h0;
    if (w == 4'h0) begin
      rd_m = cur;
    end else begin
      for (int i = 0; i < 4; i++) if (w[i]) cur[8*i +: 8] = d[8*i +: 8];
      mem_m[widx(a)] = cur;
    end
  endtask

  // Drives one complete request; returns what it observed, judges nothing.
  task automatic xact(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d,
                      input int hold, output bit req_stall, output int wait_cyc,
                      output logic [31:0] rd, output bit hold_stall, output bit timeout);
    @(posedge clk); #1;
    en = 1'b1; wen = w; addr = a; wdata = d; longest_stall = (hold > 0);
    @(negedge clk);
    req_stall = stall;
    wait_cyc = 0;
    timeout = 1'b1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (!stall) begin timeout = 1'b0; break; end
      wait_cyc++;
    end
    rd = rdata;
    hold_stall = 1'b0;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (stall || rdata !== rd) hold_stall = 1'b1;
    end
    longest_stall = 1'b0;
    @(posedge clk); #1;
    en = 1'b0; wen = 4'h0;
  endtask

  task automatic full_check(input string nm, input logic [3:0] w, input logic [31:0] a,
                            input logic [31:0] d, input int hold);
    bit rs, hs, to;
    int wc;
    logic [31:0] rd;
    model_apply(w, a, d);
    xact(w, a, d, hold, rs, wc, rd, hs, to);
    vectors++;
    if (to) begin miscompares++; $display("FAIL %s timeout: stall never dropped", nm); end
    vectors++;
    if (rs !== 1'b1) begin miscompares++; $display("FAIL %s req_stall got %b exp 1", nm, rs); end
    vectors++;
    if (wc !== LAT) begin miscompares++; $display("FAIL %s wait_cycles got %0d exp %0d", nm, wc, LAT); end
    vectors++;
    if (rd !== rd_m) begin miscompares++; $display("FAIL %s rdata got %h exp %h", nm, rd, rd_m); end
    if (hold > 0) begin
      vectors++;
      if (hs !== 1'b0) begin miscompares++; $display("FAIL %s frozen_done stall/rdata moved got 1 exp 0", nm); end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    rd_m = 32'h0;
    @(negedge clk);
    vectors++;
    if (rdata !== 32'h0) begin miscompares++; $display("FAIL reset_rdata got %h exp 00000000", rdata); end
    vectors++;
    if (stall !== 1'b0) begin miscompares++; $display("FAIL reset_stall got %b exp 0", stall); end
  endtask

  task automatic test_write_read();
    full_check("wr_deadbeef", 4'hF, 32'h10, 32'hDEADBEEF, 0);
    full_check("rd_deadbeef", 4'h0, 32'h10, 32'h0, 0);
  endtask

  task automatic test_byte_lanes();
    full_check("wr_lane0", 4'b0001, 32'h10, 32'h000000AA, 0);
    full_check("rd_lane0", 4'h0, 32'h10, 32'h0, 0);
    full_check("wr_lane23", 4'b1100, 32'h10, 32'h12340000, 0);
    full_check("rd_lane23", 4'h0, 32'h10, 32'h0, 0);
  endtask

  task automatic test_frozen();
    full_check("rd_frozen", 4'h0, 32'h10, 32'h0, 3);
    full_check("wr_after_frozen", 4'hF, 32'h14, 32'hCAFEF00D, 0);
    full_check("rd_after_frozen", 4'h0, 32'h14, 32'h0, 0);
  endtask

  task automatic test_abort();
    full_check("wr_old20", 4'hF, 32'h20, 32'hA5A5A5A5, 0);
    @(posedge clk); #1;
    en = 1'b1; wen = 4'hF; addr = 32'h20; wdata = 32'h11111111;
    @(posedge clk); #1;
    en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if (stall !== 1'b0) begin miscompares++; $display("FAIL abort_stall got %b exp 0", stall); end
    full_check("rd_after_abort", 4'h0, 32'h20, 32'h0, 0);
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    en = 1'b1; wen = 4'hF; addr = 32'h20; wdata = 32'h22222222;
    @(posedge clk); #1;
    rst = 1'b1; en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    rd_m = 32'h0;
    @(negedge clk);
    vectors++;
    if (stall !== 1'b0) begin miscompares++; $display("FAIL rstmid_stall got %b exp 0", stall); end
    vectors++;
    if (rdata !== rd_m) begin miscompares++; $display("FAIL rstmid_rdata got %h exp %h", rdata, rd_m); end
    full_check("rd_after_rstmid", 4'h0, 32'h20, 32'h0, 0);
  endtask

  task automatic test_alias();
    full_check("wr_alias", 4'hF, 32'h1004, 32'h00000055, 0);
    full_check("rd_alias", 4'h0, 32'h0004, 32'h0, 0);
  endtask

  task automatic test_back_to_back();
    int n;
    logic [31:0] exp1, exp2;
    exp1 = mem_m[widx(32'h10)];
    exp2 = mem_m[widx(32'h4)];
    @(posedge clk); #1;
    en = 1'b1; wen = 4'h0; addr = 32'h10; longest_stall = 1'b0;
    @(negedge clk);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!stall) break;
      n++;
    end
    vectors++;
    if (rdata !== exp1) begin miscompares++; $display("FAIL b2b_first_rdata got %h exp %h", rdata, exp1); end
    @(posedge clk); #1;
    addr = 32'h4;
    @(negedge clk);
    vectors++;
    if (stall !== 1'b1) begin miscompares++; $display("FAIL b2b_second_start got %b exp 1", stall); end
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!stall) break;
      n++;
    end
    vectors++;
    if (n !== LAT) begin miscompares++; $display("FAIL b2b_second_wait got %0d exp %0d", n, LAT); end
    vectors++;
    if (rdata !== exp2) begin miscompares++; $display("FAIL b2b_second_rdata got %h exp %h", rdata, exp2); end
    rd_m = exp2;
    @(posedge clk); #1;
    en = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] a, d;
    logic [3:0]  w;
    for (int i = 0; i < 8; i++) full_check("rnd_init", 4'hF, 32'h100 + 32'(4*i), $urandom, 0);
    for (int i = 0; i < 40; i++) begin
      a = (32'h100 + 32'(4 * $urandom_range(0, 7))) | (32'($urandom_range(0, 3)) << 12);
      d = $urandom;
      w = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      full_check("rnd", w, a, d, $urandom_range(0, 2));
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_frozen();
    test_abort();
    test_reset_mid();
    test_alias();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
